// File: rtl/trajectory_pkg.sv
// Shared types and default widths for the trajectory profile generator.
package trajectory_pkg;

    localparam int unsigned DEF_TICK_DIV = 50000;
    localparam int unsigned DEF_DEPTH    = 8;
    localparam int unsigned DEF_AW       = 16;
    localparam int unsigned DEF_VW       = 24;
    localparam int unsigned DEF_PW       = 32;
    localparam int unsigned DEF_DW       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Segment record layout; the top packs its table entries the same way.
    typedef struct packed {
        logic signed [DEF_AW-1:0] accel;
        logic [DEF_DW-1:0]        dur;
    } seg_t;

endpackage

// File: rtl/traj_integrator.sv
// Combinational semi-implicit integration step with saturation on both
// velocity (0..2^VW-1) and position (0..2^PW-1).
module traj_integrator #(
    parameter int unsigned AW = 16,
    parameter int unsigned VW = 24,
    parameter int unsigned PW = 32
) (
    input  logic signed [AW-1:0] accel,
    input  logic [VW-1:0]        vel,
    input  logic [PW-1:0]        pos,
    output logic [VW-1:0]        vel_next,
    output logic [PW-1:0]        pos_next,
    output logic                 sat
);

    localparam int unsigned SW = ((VW > AW) ? VW : AW) + 2;
    localparam int unsigned QW = ((PW > VW) ? PW : VW) + 1;

    logic signed [SW-1:0] vsum;
    logic signed [SW-1:0] vmax;
    logic [QW-1:0]        psum;
    logic [QW-1:0]        pmax;
    logic                 vlo;
    logic                 vhi;
    logic                 phi;

    always_comb begin
        vsum = $signed({{(SW-VW){1'b0}}, vel}) + $signed({{(SW-AW){accel[AW-1]}}, accel});
        vmax = $signed({{(SW-VW){1'b0}}, {VW{1'b1}}});
        vlo  = vsum[SW-1];
        vhi  = !vsum[SW-1] && (vsum > vmax);
        if (vlo) begin
            vel_next = '0;
        end else if (vhi) begin
            vel_next = '1;
        end else begin
            vel_next = vsum[VW-1:0];
        end

        // Position uses the freshly updated velocity and can only grow.
        psum = {{(QW-PW){1'b0}}, pos} + {{(QW-VW){1'b0}}, vel_next};
        pmax = {{(QW-PW){1'b0}}, {PW{1'b1}}};
        phi  = psum > pmax;
        pos_next = phi ? '1 : psum[PW-1:0];

        sat = vlo | vhi | phi;
    end

endmodule

// File: rtl/trajectory_profile_gen.sv
// Programmable constant-acceleration segment sequencer that integrates
// acceleration into velocity and position on a fixed simulation tick.
module trajectory_profile_gen
    import trajectory_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned VW       = DEF_VW,
    parameter int unsigned PW       = DEF_PW,
    parameter int unsigned DW       = DEF_DW,
    localparam int unsigned IW      = $clog2(DEPTH)
) (
    input  logic                 CLK_50MHZ,
    input  logic                 RST,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_addr,
    input  logic signed [AW-1:0] wr_accel,
    input  logic [DW-1:0]        wr_dur,
    input  logic [IW:0]          num_seg,
    input  logic                 start,
    input  logic                 abort,
    output logic [PW-1:0]        pos,
    output logic [VW-1:0]        vel,
    output logic [IW-1:0]        seg_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 tick,
    output logic                 sat,
    output logic                 wr_err
);

    localparam int unsigned   CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0] FIRE_AT = CW'(TICK_DIV - 2);
    localparam logic [CW-1:0] WRAP_AT = CW'(TICK_DIV - 1);

    logic [AW+DW-1:0]     seg_table [DEPTH];
    state_t               state;
    logic [IW:0]          nseg;
    logic signed [AW-1:0] accel_q;
    logic [DW-1:0]        remaining;
    logic [CW-1:0]        presc;

    logic [AW+DW-1:0]     entry;
    logic signed [AW-1:0] ent_accel;
    logic [DW-1:0]        ent_dur;
    logic signed [AW-1:0] step_accel;
    logic                 fire;
    logic                 last_seg;
    logic [VW-1:0]        vel_step;
    logic [PW-1:0]        pos_step;
    logic                 step_sat;

    assign entry      = seg_table[seg_idx];
    assign ent_accel  = entry[AW+DW-1:DW];
    assign ent_dur    = entry[DW-1:0];
    // The registered tick lands one cycle after the prescaler matches.
    assign fire       = busy && (presc == FIRE_AT);
    assign last_seg   = (({1'b0, seg_idx} + (IW+1)'(1)) == nseg);
    assign step_accel = (state == ST_LOAD) ? ent_accel : accel_q;

    traj_integrator #(
        .AW (AW),
        .VW (VW),
        .PW (PW)
    ) u_integrator (
        .accel    (step_accel),
        .vel      (vel),
        .pos      (pos),
        .vel_next (vel_step),
        .pos_next (pos_step),
        .sat      (step_sat)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (wr_en && !busy) begin
            seg_table[wr_addr] <= {wr_accel, wr_dur};
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state     <= ST_IDLE;
            pos       <= '0;
            vel       <= '0;
            seg_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tick      <= 1'b0;
            sat       <= 1'b0;
            wr_err    <= 1'b0;
            nseg      <= '0;
            accel_q   <= '0;
            remaining <= '0;
            presc     <= '0;
        end else begin
            done <= 1'b0;
            tick <= 1'b0;

            if (wr_en && busy) begin
                wr_err <= 1'b1;
            end

            if (busy) begin
                presc <= (presc == WRAP_AT) ? '0 : presc + CW'(1);
            end

            if (busy && abort) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start && !abort) begin
                            sat     <= 1'b0;
                            presc   <= '0;
                            seg_idx <= '0;
                            nseg    <= (num_seg > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : num_seg;
                            if (num_seg == '0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_LOAD;
                                busy  <= 1'b1;
                                pos   <= '0;
                                vel   <= '0;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (ent_dur == '0) begin
                            if (last_seg) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                seg_idx <= seg_idx + IW'(1);
                            end
                        end else begin
                            // A tick due during the fetch is taken straight from the
                            // table entry so short prescaler periods keep the grid.
                            accel_q   <= ent_accel;
                            state     <= ST_RUN;
                            remaining <= fire ? ent_dur - DW'(1) : ent_dur;
                            if (fire) begin
                                vel  <= vel_step;
                                pos  <= pos_step;
                                tick <= 1'b1;
                                if (step_sat) sat <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (remaining == '0) begin
                            if (last_seg) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state   <= ST_LOAD;
                                seg_idx <= seg_idx + IW'(1);
                            end
                        end else if (fire) begin
                            vel       <= vel_step;
                            pos       <= pos_step;
                            tick      <= 1'b1;
                            remaining <= remaining - DW'(1);
                            if (step_sat) sat <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
